// File: rtl/l3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : l3_mem_responder
// Brief    : Fixed-latency, single-outstanding memory responder for the L3
//            refill/writeback port, backed by an internal register file.
// Revision : 1.0 - initial release
// ============================================================================
module l3_mem_responder #(
   parameter int ADDR_W  = 6,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_wr_ack,
   output logic [15:0]       served_cnt
);

   localparam int         c_depth    = 2 ** ADDR_W;
   localparam logic [3:0] c_cnt_load = 4'(LATENCY - 1);

   if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
      $error("l3_mem_responder: LATENCY must be in 1..15");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [3:0]          r_cnt;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_mem [c_depth];
   logic [DATA_W-1:0]   r_rdata;
   logic                r_wr_ack;
   logic [15:0]         r_served_cnt;
   logic                w_accept;
   logic                w_handshake;
   logic                w_wait_done;

   // Handshake qualifiers depend only on the state register, never on req_valid for ready.
   assign req_ready   = (r_state == S_IDLE);
   assign rsp_valid   = (r_state == S_RESP);
   assign w_accept    = req_ready & req_valid;
   assign w_handshake = rsp_valid & rsp_ready;
   assign w_wait_done = (r_state == S_WAIT) && (r_cnt == 4'd1);

   assign rsp_rdata   = r_rdata;
   assign rsp_wr_ack  = r_wr_ack;
   assign served_cnt  = r_served_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_wait_done) begin
               w_next = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Writes commit at the accept edge so a following read sees the new data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < c_depth; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_accept && req_we) begin
         r_mem[req_addr] <= req_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= '0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_rdata      <= '0;
         r_wr_ack     <= 1'b0;
         r_served_cnt <= '0;
      end else begin
         if (w_accept) begin
            r_cnt  <= c_cnt_load;
            r_we   <= req_we;
            r_addr <= req_addr;
            // Single-cycle latency skips WAIT, so the response loads at the accept edge.
            if (LATENCY == 1) begin
               r_rdata  <= req_we ? '0 : r_mem[req_addr];
               r_wr_ack <= req_we;
            end
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
            if (w_wait_done) begin
               r_rdata  <= r_we ? '0 : r_mem[r_addr];
               r_wr_ack <= r_we;
            end
         end
         if (w_handshake) begin
            r_served_cnt <= r_served_cnt + 16'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_l3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_l3_mem_responder
// Brief    : Directed self-checking bench for l3_mem_responder, LATENCY=3 and
//            LATENCY=1 builds side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l3_mem_responder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // LATENCY=3 instance
   logic        a_req_valid, a_req_ready, a_req_we;
   logic [5:0]  a_req_addr;
   logic [31:0] a_req_wdata;
   logic        a_rsp_valid, a_rsp_ready, a_rsp_wr_ack;
   logic [31:0] a_rsp_rdata;
   logic [15:0] a_served_cnt;

   // LATENCY=1 instance
   logic        b_req_valid, b_req_ready, b_req_we;
   logic [5:0]  b_req_addr;
   logic [31:0] b_req_wdata;
   logic        b_rsp_valid, b_rsp_ready, b_rsp_wr_ack;
   logic [31:0] b_rsp_rdata;
   logic [15:0] b_served_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   l3_mem_responder #(.ADDR_W(6), .DATA_W(32), .LATENCY(3)) dut_a (
      .clk(clk), .rst(rst),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
      .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
      .rsp_wr_ack(a_rsp_wr_ack), .served_cnt(a_served_cnt)
   );

   l3_mem_responder #(.ADDR_W(6), .DATA_W(32), .LATENCY(1)) dut_b (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
      .rsp_wr_ack(b_rsp_wr_ack), .served_cnt(b_served_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction on the LATENCY=3 instance; response taken immediately.
   task automatic a_xfer(input logic we, input logic [5:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input string tag);
      int n;
      a_req_valid = 1'b1;
      a_req_we    = we;
      a_req_addr  = addr;
      a_req_wdata = wdata;
      tick();
      a_req_valid = 1'b0;
      chk({tag, "_ready_low"}, 32'(a_req_ready), 32'd0);
      n = 0;
      while (!a_rsp_valid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'd2);
      chk({tag, "_rdata"}, a_rsp_rdata, exp_rdata);
      chk({tag, "_wr_ack"}, 32'(a_rsp_wr_ack), 32'(we));
      a_rsp_ready = 1'b1;
      tick();
      a_rsp_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(a_rsp_valid), 32'd0);
   endtask

   task automatic a_wait_valid(input string tag);
      int n;
      n = 0;
      while (!a_rsp_valid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_reached_resp"}, 32'(a_rsp_valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1'b0;
      b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst_req_ready", 32'(a_req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
      chk("rst_rdata", a_rsp_rdata, 32'd0);
      chk("rst_wr_ack", 32'(a_rsp_wr_ack), 32'd0);
      chk("rst_served", 32'(a_served_cnt), 32'd0);
      chk("rst_b_ready", 32'(b_req_ready), 32'd1);

      // Read of a cleared location
      a_xfer(1'b0, 6'h05, 32'h0, 32'h0, "t1_rd05");
      chk("t1_served", 32'(a_served_cnt), 32'd1);

      // rsp_ready with no response pending changes nothing
      a_rsp_ready = 1'b1;
      repeat (3) tick();
      a_rsp_ready = 1'b0;
      chk("idle_rsp_ready_served", 32'(a_served_cnt), 32'd1);
      chk("idle_rsp_ready_valid", 32'(a_rsp_valid), 32'd0);

      // Write then read, plus a second address to catch aliasing
      a_xfer(1'b1, 6'h3F, 32'hDEADBEEF, 32'h0, "t2_wr3f");
      a_xfer(1'b0, 6'h3F, 32'h0, 32'hDEADBEEF, "t2_rd3f");
      a_xfer(1'b1, 6'h00, 32'h0BADF00D, 32'h0, "t2_wr00");
      a_xfer(1'b0, 6'h00, 32'h0, 32'h0BADF00D, "t2_rd00");
      a_xfer(1'b0, 6'h3F, 32'h0, 32'hDEADBEEF, "t2_rd3f_again");
      chk("t2_served", 32'(a_served_cnt), 32'd6);

      // Backpressure: response held 10 cycles; a held write request must be ignored
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 6'h3F;
      tick();
      a_req_we = 1'b1; a_req_wdata = 32'h11111111;
      a_wait_valid("t3");
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t3_hold_valid", 32'(a_rsp_valid), 32'd1);
         chk("t3_hold_rdata", a_rsp_rdata, 32'hDEADBEEF);
         chk("t3_hold_ready", 32'(a_req_ready), 32'd0);
      end
      a_req_valid = 1'b0;
      a_rsp_ready = 1'b1;
      tick();
      a_rsp_ready = 1'b0;
      chk("t3_served", 32'(a_served_cnt), 32'd7);
      a_xfer(1'b0, 6'h3F, 32'h0, 32'hDEADBEEF, "t3_no_side_effect");

      // Reset while in RESP: valid must fall asynchronously
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 6'h00;
      tick();
      a_req_valid = 1'b0;
      a_wait_valid("rstresp");
      #2 rst = 1'b1;
      #1;
      chk("rstresp_valid_async", 32'(a_rsp_valid), 32'd0);
      chk("rstresp_rdata", a_rsp_rdata, 32'd0);
      tick();
      rst = 1'b0;

      // Reset in WAIT right after a write commits
      a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 6'h02; a_req_wdata = 32'h00001234;
      tick();
      a_req_valid = 1'b0;
      chk("t4_in_wait", 32'(a_req_ready), 32'd0);
      #2 rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t4_no_rsp", 32'(a_rsp_valid), 32'd0);
      end
      chk("t4_served_cleared", 32'(a_served_cnt), 32'd0);
      a_xfer(1'b0, 6'h02, 32'h0, 32'h0, "t4_rd02");
      a_xfer(1'b0, 6'h3F, 32'h0, 32'h0, "t4_rd3f_cleared");
      chk("t4_served", 32'(a_served_cnt), 32'd2);

      // served_cnt wrap
      force dut_a.r_served_cnt = 16'hFFFE;
      #1;
      release dut_a.r_served_cnt;
      #1;
      chk("t6_preload", 32'(a_served_cnt), 32'h0000FFFE);
      a_xfer(1'b0, 6'h01, 32'h0, 32'h0, "t6_a");
      chk("t6_ffff", 32'(a_served_cnt), 32'h0000FFFF);
      a_xfer(1'b0, 6'h01, 32'h0, 32'h0, "t6_b");
      chk("t6_wrap", 32'(a_served_cnt), 32'h00000000);

      // LATENCY=1: response the cycle after accept, accepts every 2 cycles
      b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 6'h07;
      tick();
      chk("t5_rd_valid", 32'(b_rsp_valid), 32'd1);
      chk("t5_rd_ready", 32'(b_req_ready), 32'd0);
      chk("t5_rd_rdata", b_rsp_rdata, 32'd0);
      b_rsp_ready = 1'b1;
      b_req_we = 1'b1; b_req_wdata = 32'hA5A5A5A5;
      tick();
      chk("t5_hs1_valid", 32'(b_rsp_valid), 32'd0);
      chk("t5_hs1_ready", 32'(b_req_ready), 32'd1);
      chk("t5_hs1_served", 32'(b_served_cnt), 32'd1);
      tick();
      chk("t5_wr_valid", 32'(b_rsp_valid), 32'd1);
      chk("t5_wr_ack", 32'(b_rsp_wr_ack), 32'd1);
      chk("t5_wr_rdata", b_rsp_rdata, 32'd0);
      b_req_we = 1'b0;
      tick();
      chk("t5_hs2_served", 32'(b_served_cnt), 32'd2);
      tick();
      chk("t5_rd2_valid", 32'(b_rsp_valid), 32'd1);
      chk("t5_rd2_rdata", b_rsp_rdata, 32'hA5A5A5A5);
      chk("t5_rd2_ack", 32'(b_rsp_wr_ack), 32'd0);
      b_req_valid = 1'b0;
      tick();
      chk("t5_hs3_served", 32'(b_served_cnt), 32'd3);
      b_rsp_ready = 1'b0;
      tick();
      chk("t5_idle_valid", 32'(b_rsp_valid), 32'd0);
      chk("t5_idle_ready", 32'(b_req_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
